// File: rtl/lampFPU_pkg.sv
// Shared widths and state encoding for the sqrt request sequencer.
package lampFPU_pkg;
    localparam int LAMP_FLOAT_F_DW = 7;
    localparam int SQRT_OP_DW      = 1 + LAMP_FLOAT_F_DW;
    localparam int SQRT_RES_DW     = 2 * SQRT_OP_DW;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } sqrtReqState_t;
endpackage

// File: rtl/sqrt_req_fifo.sv
// Operand queue: DEPTH entries, pointers carry an extra MSB to tell full from empty.
module sqrt_req_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DW-1:0]            din,
    input  logic                     pop,
    output logic [DW-1:0]            dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign count   = wr_ptr - rd_ptr;
    assign dout    = mem[rd_ptr[AW-1:0]];
    // A full queue refuses a push even when the head is popped in the same cycle.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/sqrt_req_sequencer.sv
// Queues operands and issues them one at a time on the doSqrt/valid handshake.
// Optional ISSUE timeout with res_err_o is enabled by defining SQRT_REQ_TIMEOUT_EN.
module sqrt_req_sequencer
    import lampFPU_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   op_valid_i,
    input  logic [SQRT_OP_DW-1:0]  op_i,
    output logic                   op_ready_o,
    output logic                   doSqrt_o,
    output logic [SQRT_OP_DW-1:0]  s_o,
    input  logic                   valid_i,
    input  logic [SQRT_RES_DW-1:0] res_i,
    output logic                   res_valid_o,
    output logic [SQRT_RES_DW-1:0] res_o,
    input  logic                   res_ready_i,
    output logic                   busy_o,
`ifdef SQRT_REQ_TIMEOUT_EN
    output logic                   res_err_o,
`endif
    output logic [1:0]             state_o
);
    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_ISSUE = ISSUE;
    localparam logic [1:0] ST_RESP  = RESP;
    localparam int         CW       = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]            state;
    logic [1:0]            state_next;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CW-1:0]         fifo_count;
    logic [CW-1:0]         cnt_next;
    logic [SQRT_OP_DW-1:0] fifo_head;
    logic                  push;
    logic                  pop;
    logic                  timeout;

    assign op_ready_o = !fifo_full;
    assign push       = op_valid_i && !fifo_full;
    assign pop        = (state == ST_IDLE) && !fifo_empty;
    assign cnt_next   = fifo_count + CW'(push) - CW'(pop);
    assign state_o    = state;

    sqrt_req_fifo #(.DW(SQRT_OP_DW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (op_i),
        .pop   (pop),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

`ifdef SQRT_REQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_cnt;

    // A response arriving on the limit cycle takes priority over the timeout.
    assign timeout = (state == ST_ISSUE) && (to_cnt == TW'(TIMEOUT_CYCLES - 1)) && !valid_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt    <= '0;
            res_err_o <= 1'b0;
        end else begin
            if (pop)                    to_cnt <= '0;
            else if (state == ST_ISSUE) to_cnt <= to_cnt + 1'b1;
            if (timeout)                              res_err_o <= 1'b1;
            else if (state == ST_RESP && res_ready_i) res_err_o <= 1'b0;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (!fifo_empty)          state_next = ST_ISSUE;
            ST_ISSUE: if (valid_i || timeout)   state_next = ST_RESP;
            ST_RESP:  if (res_ready_i)          state_next = ST_IDLE;
            default:                            state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            doSqrt_o    <= 1'b0;
            s_o         <= '0;
            res_valid_o <= 1'b0;
            res_o       <= '0;
            busy_o      <= 1'b0;
        end else begin
            state  <= state_next;
            busy_o <= (state_next != ST_IDLE) || (cnt_next != '0);
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        s_o      <= fifo_head;
                        doSqrt_o <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (valid_i) begin
                        doSqrt_o    <= 1'b0;
                        res_valid_o <= 1'b1;
                        res_o       <= res_i;
                    end else if (timeout) begin
                        doSqrt_o    <= 1'b0;
                        res_valid_o <= 1'b1;
                        res_o       <= '1;
                    end
                end
                ST_RESP: begin
                    if (res_ready_i) res_valid_o <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sqrt_req_sequencer.sv
// Bench for sqrt_req_sequencer: responder model, result scoreboard, vector table, corner sequences.
`timescale 1ns/1ps
module tb_sqrt_req_sequencer;
    import lampFPU_pkg::*;
    localparam int OW = SQRT_OP_DW;
    localparam int RW = SQRT_RES_DW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          op_valid_i = 1'b0;
    logic [OW-1:0] op_i = '0;
    logic          op_ready_o;
    logic          doSqrt_o;
    logic [OW-1:0] s_o;
    logic          valid_i;
    logic [RW-1:0] res_i;
    logic          res_valid_o;
    logic [RW-1:0] res_o;
    logic          res_ready_i = 1'b0;
    logic          busy_o;
    logic [1:0]    state_o;
    logic          act_err;

    int checks = 0;
    int errors = 0;
    logic [RW:0] exp_q[$];

    logic          resp_en = 1'b0;
    int            resp_lat = 1;
    int            ready_wait = 0;
    logic          resp_valid = 1'b0;
    logic [RW-1:0] resp_res = '0;
    logic          spur = 1'b0;

    assign valid_i = resp_valid | spur;
    assign res_i   = spur ? 16'hBEEF : resp_res;

    always #5 clk = ~clk;

`ifdef SQRT_REQ_TIMEOUT_EN
    logic res_err_o;
    assign act_err = res_err_o;
    sqrt_req_sequencer #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .op_valid_i(op_valid_i), .op_i(op_i), .op_ready_o(op_ready_o),
        .doSqrt_o(doSqrt_o), .s_o(s_o), .valid_i(valid_i), .res_i(res_i),
        .res_valid_o(res_valid_o), .res_o(res_o), .res_ready_i(res_ready_i),
        .busy_o(busy_o), .res_err_o(res_err_o), .state_o(state_o));
`else
    assign act_err = 1'b0;
    sqrt_req_sequencer #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .op_valid_i(op_valid_i), .op_i(op_i), .op_ready_o(op_ready_o),
        .doSqrt_o(doSqrt_o), .s_o(s_o), .valid_i(valid_i), .res_i(res_i),
        .res_valid_o(res_valid_o), .res_o(res_o), .res_ready_i(res_ready_i),
        .busy_o(busy_o), .state_o(state_o));
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // Fixed-point square root: result has 8 fraction bits.
    function automatic logic [RW-1:0] model_sqrt(input logic [OW-1:0] s);
        logic [31:0] x;
        logic [31:0] t;
        logic [31:0] r;
        x = 32'(s) << 16;
        r = '0;
        for (int b = RW - 1; b >= 0; b--) begin
            t = r | (32'd1 << b);
            if (t * t <= x) r = t;
        end
        return r[RW-1:0];
    endfunction

    // Responder model and result-side scoreboard, both evaluated at the falling edge.
    int            hi_cnt = 0;
    int            hi_len = 0;
    int            last_hi_len = 0;
    int            low_cnt = 2;
    int            hold_cnt = 0;
    logic          prev_do = 1'b0;
    logic          prev_rv = 1'b0;
    logic          prev_hs = 1'b0;
    logic [OW-1:0] s_hold = '0;
    logic [RW-1:0] prev_res = '0;
    logic [RW:0]   exp_item;

    always @(negedge clk) begin
        if (!rst) begin
            hi_cnt = 0; hi_len = 0; low_cnt = 2; hold_cnt = 0;
            prev_do = 1'b0; prev_rv = 1'b0; prev_hs = 1'b0;
            resp_valid = 1'b0; res_ready_i = 1'b0;
        end else begin
            if (doSqrt_o) begin
                if (!prev_do) begin
                    s_hold = s_o;
                    check("req_gap", 32'(low_cnt >= 2), 32'd1);
                end else begin
                    check("s_stable", 32'(s_o), 32'(s_hold));
                end
                low_cnt = 0;
                hi_len++;
                hi_cnt++;
                resp_valid = resp_en && (hi_cnt >= resp_lat);
                if (resp_valid) resp_res = model_sqrt(s_o);
            end else begin
                if (prev_do) last_hi_len = hi_len;
                hi_len = 0; hi_cnt = 0; resp_valid = 1'b0;
                low_cnt++;
            end
            prev_do = doSqrt_o;

            if (res_valid_o) begin
                check("no_req_in_resp", 32'(doSqrt_o), 32'd0);
                if (prev_rv && !prev_hs) check("res_stable", 32'(res_o), 32'(prev_res));
                res_ready_i = (hold_cnt >= ready_wait);
                hold_cnt++;
                prev_hs = res_ready_i;
                if (res_ready_i) begin
                    hold_cnt = 0;
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_result");
                    end else begin
                        exp_item = exp_q.pop_front();
                        check("result", 32'({act_err, res_o}), 32'(exp_item));
                    end
                end
            end else begin
                res_ready_i = 1'b0;
                hold_cnt = 0;
                prev_hs = 1'b0;
            end
            prev_rv = res_valid_o;
            prev_res = res_o;
        end
    end

    // Called at a falling edge; returns at the falling edge after the accepting edge.
    task automatic push_op(input logic [OW-1:0] v, input logic [RW:0] exp);
        int n;
        n = 0;
        op_valid_i = 1'b1;
        op_i = v;
        while (!op_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!op_ready_o) fail_now("push_ready");
        else exp_q.push_back(exp);
        @(negedge clk);
        op_valid_i = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && !busy_o && !res_valid_o) && n < max) begin
            @(negedge clk);
            n++;
        end
        if (n >= max) fail_now("drain");
    endtask

    task automatic wait_res_valid(input int max);
        int n;
        n = 0;
        while (!res_valid_o && n < max) begin
            @(negedge clk);
            n++;
        end
        if (!res_valid_o) fail_now("res_valid_wait");
    endtask

    typedef struct {
        logic [OW-1:0] op;
        int            lat;
        int            rwait;
        logic [RW-1:0] exp_res;
    } vec_t;
    vec_t vecs[6];

    initial begin
        int n;
        vecs[0] = '{8'h19, 3, 0, 16'h0500};
        vecs[1] = '{8'h04, 1, 2, 16'h0200};
        vecs[2] = '{8'h00, 5, 0, 16'h0000};
        vecs[3] = '{8'h90, 2, 1, 16'h0C00};
        vecs[4] = '{8'hE1, 7, 3, 16'h0F00};
        vecs[5] = '{8'h79, 4, 0, 16'h0B00};

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_do", 32'(doSqrt_o), 32'd0);
        check("rst_s", 32'(s_o), 32'd0);
        check("rst_rv", 32'(res_valid_o), 32'd0);
        check("rst_res", 32'(res_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_err", 32'(act_err), 32'd0);
        check("rst_state", 32'(state_o), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_ready", 32'(op_ready_o), 32'd1);

        // Single op with latency
        resp_en = 1'b1; resp_lat = 3; ready_wait = 0;
        push_op(8'h19, {1'b0, 16'h0500});
        check("lat_k1_do", 32'(doSqrt_o), 32'd0);
        check("lat_k1_busy", 32'(busy_o), 32'd1);
        @(negedge clk);
        check("lat_k2_do", 32'(doSqrt_o), 32'd1);
        check("lat_k2_s", 32'(s_o), 32'h19);
        wait_res_valid(20);
        check("single_res", 32'(res_o), 32'h0500);
        check("single_do_low", 32'(doSqrt_o), 32'd0);
        wait_idle(50);
        check("single_len", 32'(last_hi_len), 32'd3);

        // Vector table
        for (int i = 0; i < 6; i++) begin
            resp_lat = vecs[i].lat;
            ready_wait = vecs[i].rwait;
            push_op(vecs[i].op, {1'b0, vecs[i].exp_res});
            wait_idle(100);
            check("vec_len", 32'(last_hi_len), 32'(vecs[i].lat));
        end

        // Backpressure with a second op queued
        resp_lat = 2; ready_wait = 10;
        push_op(8'h09, {1'b0, 16'h0300});
        push_op(8'h40, {1'b0, 16'h0800});
        wait_res_valid(20);
        n = 0;
        while (res_valid_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("bp_hold", 32'(n), 32'd11);
        check("bp_idle_gap", 32'(doSqrt_o), 32'd0);
        @(negedge clk);
        check("bp_next_do", 32'(doSqrt_o), 32'd1);
        check("bp_next_s", 32'(s_o), 32'h40);
        ready_wait = 0;
        wait_idle(100);

        // Fill with the responder stalled
        resp_en = 1'b0;
        for (int v = 1; v <= 5; v++) push_op(OW'(v), {1'b0, model_sqrt(OW'(v))});
        op_valid_i = 1'b1; op_i = 8'h06;
        for (int i = 0; i < 3; i++) begin
            check("fill_ready", 32'(op_ready_o), 32'd0);
            @(negedge clk);
        end
        op_valid_i = 1'b0;
        check("fill_do", 32'(doSqrt_o), 32'd1);
        check("fill_s", 32'(s_o), 32'h01);
        check("fill_busy", 32'(busy_o), 32'd1);
        resp_lat = 2; resp_en = 1'b1;
        wait_idle(300);
        check("fill_drained", 32'(exp_q.size()), 32'd0);

        // Spurious valid_i while idle
        spur = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("spur_rv", 32'(res_valid_o), 32'd0);
            check("spur_state", 32'(state_o), 32'd0);
            check("spur_busy", 32'(busy_o), 32'd0);
        end
        spur = 1'b0;

        // Reset during ISSUE with ops queued
        resp_en = 1'b0;
        push_op(8'h19, {1'b0, 16'h0500});
        push_op(8'h04, {1'b0, 16'h0200});
        push_op(8'h01, {1'b0, 16'h0100});
        check("mid_do", 32'(doSqrt_o), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_do", 32'(doSqrt_o), 32'd0);
        check("mid_rst_rv", 32'(res_valid_o), 32'd0);
        check("mid_rst_busy", 32'(busy_o), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(op_ready_o), 32'd1);
        check("post_rst_busy", 32'(busy_o), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_rv", 32'(res_valid_o), 32'd0);
            check("post_rst_do", 32'(doSqrt_o), 32'd0);
        end
        resp_en = 1'b1; resp_lat = 2;
        push_op(8'h40, {1'b0, 16'h0800});
        wait_idle(100);

`ifdef SQRT_REQ_TIMEOUT_EN
        // Timeout with a silent responder, then a response on the limit cycle
        resp_en = 1'b0;
        push_op(8'h19, {1'b1, 16'hFFFF});
        wait_idle(100);
        check("to_len", 32'(last_hi_len), 32'd8);
        check("to_err_clr", 32'(act_err), 32'd0);
        resp_en = 1'b1; resp_lat = 8;
        push_op(8'h19, {1'b0, 16'h0500});
        wait_idle(100);
        check("to_edge_len", 32'(last_hi_len), 32'd8);
`endif

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
